reset_release_seq: RTL and testbench

//  Consumer end of the system reset pulse. Takes the synchronous active-high reset pulse

---
 rtl/reset_seq_pkg.sv | 37 +++
 rtl/reset_seq_timer.sv | 50 +++++
 rtl/reset_release_seq.sv | 176 +++++++++++++++++
 tb/tb_reset_release_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : reset_seq_pkg
// Purpose : Shared types and helpers for the reset release sequencer.
//           Holds the sequencer state enum, a ceil-log2 helper and the
//           stage index width. The index width is sized for the largest
//           supported stage count, which also matches the 4-bit
//           fail_stage_o port.
// Revision: 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ARM      = 3'd0,
    ST_HOLD     = 3'd1,
    ST_GAP      = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_e;

  localparam int MAX_STAGES = 16;

  // Ceil-log2 with a floor of 1, so a single-entry range still gets one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int IDX_W = clog2(MAX_STAGES);

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq_timer.sv
`default_nettype none
// ============================================================================
// Module  : reset_seq_timer
// Purpose : Clear/enable up-counter that saturates at all ones, with an
//           equality compare against a caller-supplied terminal value.
//           The sequencer shares one instance between its gap and its
//           ready-timeout intervals.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           clr_i  - synchronous clear (wins over en_i)
//           en_i   - count enable
//           cmp_i  - terminal value
//           tc_o   - count equals cmp_i (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module reset_seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == cmp_i);

endmodule : reset_seq_timer
`default_nettype wire

// File: rtl/reset_release_seq.sv
`default_nettype none
// ============================================================================
// Module  : reset_release_seq
// Purpose : Consumer of the board reset pulse. After the generator's pulse
//           ends, releases NUM_STAGES downstream reset domains one at a time,
//           waiting GAP cycles before each release and for the released
//           stage's ready ack before moving on. A stage that stays not-ready
//           for TIMEOUT samples raises a sticky fault and re-asserts every
//           stage reset.
// Ports   : clk            - system clock
//           async_rst_n_i  - asynchronous active-low reset
//           rst_i          - synchronous active-high reset pulse
//           stage_rdy_i    - per-stage ready ack (level)
//           stage_rst_o    - per-stage active-high reset (registered)
//           sys_ready_o    - all stages released and acked
//           busy_o         - sequencing in progress
//           timeout_o      - sticky fault flag
//           fail_stage_o   - index of the stage that timed out
// Revision: 1.0 - initial release
// ============================================================================
module reset_release_seq
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int GAP        = 8,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  async_rst_n_i,
  input  logic                  rst_i,
  input  logic [NUM_STAGES-1:0] stage_rdy_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  sys_ready_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [3:0]            fail_stage_o
);

  localparam logic [CNT_W-1:0] c_gap_tc  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] c_to_tc   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_last_ix = IDX_W'(NUM_STAGES - 1);

  state_e                  state_d,      state_q;
  logic [IDX_W-1:0]        idx_d,        idx_q;
  logic [NUM_STAGES-1:0]   stage_rst_d,  stage_rst_q;
  logic                    sys_ready_d,  sys_ready_q;
  logic                    busy_d,       busy_q;
  logic                    timeout_d,    timeout_q;
  logic [3:0]              fail_stage_d, fail_stage_q;

  logic                    tmr_clr;
  logic                    tmr_en;
  logic [CNT_W-1:0]        tmr_cmp;
  logic                    tmr_tc;
  logic                    cur_rdy;
  logic [NUM_STAGES-1:0]   cur_mask;

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (async_rst_n_i),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .cmp_i (tmr_cmp),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stage_rst_d  = stage_rst_q;
    sys_ready_d  = sys_ready_q;
    timeout_d    = timeout_q;
    fail_stage_d = fail_stage_q;
    // The timer is held cleared unless a state explicitly lets it count.
    tmr_clr      = 1'b1;
    tmr_en       = 1'b0;
    tmr_cmp      = c_gap_tc;

    // Only the current stage's ack is visible; all other rdy bits are dropped.
    cur_rdy  = 1'b0;
    cur_mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_rdy     = stage_rdy_i[i];
        cur_mask[i] = 1'b1;
      end
    end

    if (rst_i && (state_q != ST_ARM)) begin
      // A new reset pulse overrides everything, including a pending ack or
      // a terminal count on this very edge.
      state_d      = ST_HOLD;
      idx_d        = '0;
      stage_rst_d  = '1;
      sys_ready_d  = 1'b0;
      timeout_d    = 1'b0;
      fail_stage_d = '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (rst_i) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          state_d = ST_GAP;
          idx_d   = '0;
        end
        ST_GAP: begin
          if (tmr_tc) begin
            stage_rst_d = stage_rst_q & ~cur_mask;
            state_d     = ST_WAIT_RDY;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        ST_WAIT_RDY: begin
          tmr_cmp = c_to_tc;
          if (cur_rdy) begin
            if (idx_q == c_last_ix) begin
              state_d     = ST_DONE;
              sys_ready_d = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ST_GAP;
            end
          end else if (tmr_tc) begin
            // This edge takes the TIMEOUT-th consecutive low sample.
            state_d      = ST_FAULT;
            timeout_d    = 1'b1;
            fail_stage_d = 4'(idx_q);
            stage_rst_d  = '1;
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        default: begin
          // DONE and FAULT hold until a reset pulse.
        end
      endcase
    end

    busy_d = (state_d == ST_GAP) || (state_d == ST_WAIT_RDY);
  end

  always_ff @(posedge clk or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      state_q      <= ST_ARM;
      idx_q        <= '0;
      stage_rst_q  <= '1;
      sys_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_stage_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stage_rst_q  <= stage_rst_d;
      sys_ready_q  <= sys_ready_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      fail_stage_q <= fail_stage_d;
    end
  end

  assign stage_rst_o  = stage_rst_q;
  assign sys_ready_o  = sys_ready_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;
  assign fail_stage_o = fail_stage_q;

endmodule : reset_release_seq
`default_nettype wire

// File: tb/tb_reset_release_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_release_seq
// Purpose : Self-checking bench for reset_release_seq. A timeline model
//           derives, from the per-stage ack delays, the edge at which each
//           stage is released, the edge the sequence completes or faults,
//           and compares the outputs after every clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reset_release_seq;

  localparam int N    = 4;
  localparam int GAP  = 8;
  localparam int TO   = 16;
  localparam int CW   = 32;
  localparam int NEVER = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         async_rst_n_i;
  logic         rst_i;
  logic [N-1:0] stage_rdy_i;
  logic [N-1:0] stage_rst_o;
  logic         sys_ready_o;
  logic         busy_o;
  logic         timeout_o;
  logic [3:0]   fail_stage_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reset_release_seq #(
    .NUM_STAGES (N),
    .GAP        (GAP),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .async_rst_n_i (async_rst_n_i),
    .rst_i         (rst_i),
    .stage_rdy_i   (stage_rdy_i),
    .stage_rst_o   (stage_rst_o),
    .sys_ready_o   (sys_ready_o),
    .busy_o        (busy_o),
    .timeout_o     (timeout_o),
    .fail_stage_o  (fail_stage_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold rst_i high for len edges; every stage must stay in reset.
  task automatic pulse(input int len);
    rst_i = 1'b1;
    for (int i = 0; i < len; i++) begin
      stage_rdy_i = N'($urandom);
      step();
      total++;
      if ({stage_rst_o, busy_o, sys_ready_o, timeout_o} !== {{N{1'b1}}, 3'b000}) begin
        bad++;
        $display("FAIL pulse_hold cyc=%0d got rst=%b busy=%b rdy=%b to=%b exp rst=%b busy=0 rdy=0 to=0",
                 i, stage_rst_o, busy_o, sys_ready_o, timeout_o, {N{1'b1}});
      end
    end
  endtask

  // Runs one sequence after a pulse. d[k] is the number of edges after
  // stage k's release at which its ack is first sampled high; d[k] > TO means
  // it never acks in time. abort_e >= 0 samples rst_i high at that edge.
  // hold3 keeps the last stage's rdy high outside its own sampling window.
  task automatic run_seq(input string name, input int d [N], input int abort_e, input bit hold3);
    int           rel [N];
    int           win_end [N];
    bit           reached [N];
    int           done_e, fault_e, fstage, r, last_e;
    logic [N-1:0] e_rst;
    logic [N+6:0] exp_v, got_v;
    bit           e_to;

    done_e  = NEVER;
    fault_e = NEVER;
    fstage  = 0;
    r       = GAP;
    for (int k = 0; k < N; k++) begin
      reached[k] = 1'b0;
      rel[k]     = NEVER;
      win_end[k] = -1;
    end
    for (int k = 0; k < N; k++) begin
      reached[k] = 1'b1;
      rel[k]     = r;
      if (d[k] > TO) begin
        fault_e    = r + TO;
        fstage     = k;
        win_end[k] = r + TO;
        break;
      end
      win_end[k] = r + d[k];
      if (k == N - 1) done_e = r + d[k];
      else            r      = r + d[k] + GAP;
    end

    if (abort_e >= 0) last_e = abort_e;
    else              last_e = ((done_e < fault_e) ? done_e : fault_e) + 4;

    for (int e = 0; e <= last_e; e++) begin
      rst_i = (e == abort_e);
      for (int k = 0; k < N; k++) begin
        if (reached[k] && (e > rel[k]) && (e <= win_end[k]))
          stage_rdy_i[k] = (e == rel[k] + d[k]);
        else if (hold3 && (k == N - 1))
          stage_rdy_i[k] = 1'b1;
        else
          stage_rdy_i[k] = 1'($urandom_range(0, 1));
      end
      step();

      if (e == abort_e) begin
        exp_v = {{N{1'b1}}, 3'b000, 4'h0};
        got_v = {stage_rst_o, busy_o, sys_ready_o, timeout_o, 4'h0};
      end else begin
        e_rst = '1;
        for (int k = 0; k < N; k++)
          if (reached[k] && (e >= rel[k])) e_rst[k] = 1'b0;
        e_to = (e >= fault_e);
        if (e_to) e_rst = '1;
        exp_v = {e_rst, (e < done_e) && !e_to, e >= done_e, e_to, e_to ? 4'(fstage) : 4'h0};
        got_v = {stage_rst_o, busy_o, sys_ready_o, timeout_o, e_to ? fail_stage_o : 4'h0};
      end
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL %s edge=%0d got {rst,busy,rdy,to,fs}=%b exp=%b", name, e, got_v, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    async_rst_n_i = 1'b0;
    rst_i         = 1'b0;
    stage_rdy_i   = '1;
    step();
    step();
    total++;
    if ({stage_rst_o, sys_ready_o, busy_o, timeout_o, fail_stage_o} !== {{N{1'b1}}, 3'b000, 4'h0}) begin
      bad++;
      $display("FAIL reset_values got rst=%b rdy=%b busy=%b to=%b fs=%0d exp rst=1111 0 0 0 0",
               stage_rst_o, sys_ready_o, busy_o, timeout_o, fail_stage_o);
    end
    @(negedge clk);
    async_rst_n_i = 1'b1;
    step();
    total++;
    if ({stage_rst_o, busy_o} !== {{N{1'b1}}, 1'b0}) begin
      bad++;
      $display("FAIL reset_release got rst=%b busy=%b exp rst=1111 busy=0", stage_rst_o, busy_o);
    end
  endtask

  task automatic test_no_pulse();
    rst_i = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      stage_rdy_i = N'($urandom);
      step();
      total++;
      if ({stage_rst_o, busy_o, sys_ready_o} !== {{N{1'b1}}, 2'b00}) begin
        bad++;
        $display("FAIL no_pulse cyc=%0d got rst=%b busy=%b rdy=%b exp rst=1111 busy=0 rdy=0",
                 i, stage_rst_o, busy_o, sys_ready_o);
      end
    end
  endtask

  task automatic test_all_ready();
    int d [N];
    foreach (d[k]) d[k] = 1;
    pulse(5);
    run_seq("all_ready", d, -1, 1'b0);
  endtask

  task automatic test_timeout();
    int d [N];
    foreach (d[k]) d[k] = 1;
    d[2] = TO + 5;
    pulse(5);
    run_seq("timeout_stage2", d, -1, 1'b0);
  endtask

  task automatic test_fault_recover();
    int d [N];
    foreach (d[k]) d[k] = $urandom_range(1, 10);
    pulse(3);
    run_seq("fault_recover", d, -1, 1'b0);
  endtask

  task automatic test_abort_wait();
    int d [N];
    foreach (d[k]) d[k] = 1;
    d[1] = 10;
    pulse(2);
    run_seq("abort_wait1", d, 2 * GAP + d[0] + 3, 1'b0);
    pulse(4);
    d[1] = 2;
    run_seq("after_abort", d, -1, 1'b0);
  endtask

  task automatic test_priority();
    int d [N];
    foreach (d[k]) d[k] = 3;
    pulse(2);
    run_seq("abort_on_ack", d, GAP + d[0], 1'b0);
    pulse(2);
    run_seq("abort_on_gap_tc", d, GAP, 1'b0);
    d[0] = TO + 5;
    pulse(2);
    run_seq("abort_on_timeout_tc", d, GAP + TO, 1'b0);
    d[0] = 3;
    pulse(2);
    run_seq("after_priority", d, -1, 1'b0);
  endtask

  task automatic test_early_rdy3();
    int d [N];
    foreach (d[k]) d[k] = 1;
    pulse(5);
    run_seq("early_rdy3", d, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int d [N];
    for (int it = 0; it < 8; it++) begin
      foreach (d[k]) d[k] = $urandom_range(1, TO + 2);
      pulse($urandom_range(1, 4));
      run_seq("random_seq", d, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_no_pulse();
    test_all_ready();
    test_timeout();
    test_fault_recover();
    test_abort_wait();
    test_priority();
    test_early_rdy3();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reset_release_seq
`default_nettype wire
